// File: rtl/timing_gen.sv
// Two-phase clock and subcycle sequencer for the i4004 core: divides sysclk into
// subcycles, walks A1..X3, and emits registered clk1/clk2 plus phase strobes.
module timing_gen #(
   parameter int SUB_LEN    = 68,
   parameter int CLK1_START = 0,
   parameter int CLK1_W     = 20,
   parameter int CLK2_START = 34,
   parameter int CLK2_W     = 20
) (
   input  logic       sysclk,
   input  logic       poc,
   input  logic       halt_req,
   output logic       halt_ack,
   output logic       clk1,
   output logic       clk2,
   output logic       sync,
   output logic       a12,
   output logic       a22,
   output logic       a32,
   output logic       m12,
   output logic       m22,
   output logic       x12,
   output logic       x22,
   output logic       x32,
   output logic       m11,
   output logic       m21,
   output logic       m12_m22_clk1_m11_m12,
   output logic [2:0] subcycle
);

   localparam int TW = $clog2(SUB_LEN);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t        state;
   logic [TW-1:0] t;
   logic [2:0]    s;
   int            tick;

   // Signed view of the tick counter so window compares against a zero offset stay clean.
   assign tick = int'(t);

   always_ff @(posedge sysclk) begin
      if (poc) begin
         state    <= ST_RESET;
         t        <= '0;
         s        <= '0;
         halt_ack <= 1'b0;
         clk1     <= 1'b0;
         clk2     <= 1'b0;
         sync     <= 1'b0;
         a12      <= 1'b0;
         a22      <= 1'b0;
         a32      <= 1'b0;
         m12      <= 1'b0;
         m22      <= 1'b0;
         x12      <= 1'b0;
         x22      <= 1'b0;
         x32      <= 1'b0;
         m11      <= 1'b0;
         m21      <= 1'b0;
         subcycle <= '0;
      end else begin
         case (state)
            ST_RESET: begin
               state <= ST_RUN;
            end

            ST_RUN: begin
               clk1     <= (tick >= CLK1_START) && (tick < CLK1_START + CLK1_W);
               clk2     <= (tick >= CLK2_START) && (tick < CLK2_START + CLK2_W);
               subcycle <= s;

               // Strobes are only reloaded on their own clock edge, so each spans a full subcycle.
               if (tick == CLK2_START) begin
                  a12 <= (s == 3'd0);
                  a22 <= (s == 3'd1);
                  a32 <= (s == 3'd2);
                  m12 <= (s == 3'd3);
                  m22 <= (s == 3'd4);
                  x12 <= (s == 3'd5);
                  x22 <= (s == 3'd6);
                  x32 <= (s == 3'd7);
               end

               if (tick == CLK1_START) begin
                  m11  <= (s == 3'd3);
                  m21  <= (s == 3'd4);
                  sync <= (s == 3'd7);
               end

               if (tick == SUB_LEN - 1) begin
                  t <= '0;
                  if ((s == 3'd7) && halt_req) begin
                     state    <= ST_HALT;
                     s        <= '0;
                     halt_ack <= 1'b1;
                  end else begin
                     s <= s + 3'd1;
                  end
               end else begin
                  t <= t + TW'(1);
               end
            end

            ST_HALT: begin
               // Outputs freeze at their end-of-X3 values; clk1/clk2 are already low there.
               if (!halt_req) begin
                  state    <= ST_RUN;
                  halt_ack <= 1'b0;
               end
            end

            default: begin
               state <= ST_RESET;
            end
         endcase
      end
   end

   assign m12_m22_clk1_m11_m12 = m12 | m22 | (clk1 & ~(m11 | m12));

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: reset release, full instruction cycle,
// din-latch enable, halt handshake, short halt pulses and mid-run reset.
module tb_timing_gen;

   logic       sysclk = 1'b0;
   logic       poc;
   logic       halt_req;
   logic       halt_ack;
   logic       clk1;
   logic       clk2;
   logic       sync;
   logic       a12, a22, a32, m12, m22, x12, x22, x32;
   logic       m11, m21;
   logic       ena;
   logic [2:0] subcycle;

   int n_cmp = 0;
   int n_bad = 0;
   int cur_p = 0;

   logic [17:0] outs;
   localparam logic [17:0] HALT_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_0001, 1'b0, 1'b0, 1'b0, 3'd7};
   localparam logic [17:0] RESUME_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0001, 1'b0, 1'b0, 1'b0, 3'd7};

   timing_gen dut (
      .sysclk               (sysclk),
      .poc                  (poc),
      .halt_req             (halt_req),
      .halt_ack             (halt_ack),
      .clk1                 (clk1),
      .clk2                 (clk2),
      .sync                 (sync),
      .a12                  (a12),
      .a22                  (a22),
      .a32                  (a32),
      .m12                  (m12),
      .m22                  (m22),
      .x12                  (x12),
      .x22                  (x22),
      .x32                  (x32),
      .m11                  (m11),
      .m21                  (m21),
      .m12_m22_clk1_m11_m12 (ena),
      .subcycle             (subcycle)
   );

   always #5 sysclk = ~sysclk;

   assign outs = {halt_ack, clk1, clk2, sync, a12, a22, a32, m12, m22, x12, x22, x32,
                  m11, m21, ena, subcycle};

   // Expected outputs at position p, counted in ticks from the first A1 clk1 rise.
   function automatic logic [17:0] exp_run(int p);
      int t, s;
      logic [2:0] s3, sp;
      logic [7:0] st;
      logic c1, c2, e11, e21, sy, e;
      t   = p % 68;
      s   = (p / 68) % 8;
      s3  = 3'(s);
      sp  = 3'((s + 7) % 8);
      c1  = (t < 20);
      c2  = (t >= 34) && (t < 54);
      st  = '0;
      if (t >= 34) st[s3] = 1'b1;
      else if (p >= 68) st[sp] = 1'b1;
      e11 = (s == 3);
      e21 = (s == 4);
      sy  = (s == 7);
      e   = st[3] | st[4] | (c1 & ~(e11 | st[3]));
      return {1'b0, c1, c2, sy, st[0], st[1], st[2], st[3], st[4], st[5], st[6], st[7],
              e11, e21, e, s3};
   endfunction

   task automatic do_reset();
      poc = 1'b1;
      halt_req = 1'b0;
      repeat (3) @(negedge sysclk);
      poc = 1'b0;
      @(negedge sysclk);
      cur_p = -1;
   endtask

   task automatic run_to(int target);
      while (cur_p < target) begin
         @(negedge sysclk);
         cur_p++;
      end
   endtask

   task automatic test_reset();
      poc = 1'b1;
      halt_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge sysclk);
         n_cmp++;
         if (outs !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, outs, 18'd0);
         end
      end
      poc = 1'b0;
      @(negedge sysclk);
      n_cmp++;
      if (outs !== 18'd0) begin
         n_bad++;
         $display("FAIL release_edge got=%b exp=%b", outs, 18'd0);
      end
      for (int n = 1; n <= 40; n++) begin
         @(negedge sysclk);
         n_cmp++;
         if (clk1 !== (n <= 20)) begin
            n_bad++;
            $display("FAIL rel_clk1 n=%0d got=%b exp=%b", n, clk1, (n <= 20));
         end
         n_cmp++;
         if (clk2 !== (n >= 35)) begin
            n_bad++;
            $display("FAIL rel_clk2 n=%0d got=%b exp=%b", n, clk2, (n >= 35));
         end
         n_cmp++;
         if (a12 !== (n >= 35)) begin
            n_bad++;
            $display("FAIL rel_a12 n=%0d got=%b exp=%b", n, a12, (n >= 35));
         end
         n_cmp++;
         if (subcycle !== 3'd0) begin
            n_bad++;
            $display("FAIL rel_subcycle n=%0d got=%0d exp=0", n, subcycle);
         end
      end
   endtask

   task automatic test_full_cycle();
      do_reset();
      for (int p = 0; p < 8 * 68 + 70; p++) begin
         @(negedge sysclk);
         cur_p = p;
         n_cmp++;
         if (outs !== exp_run(p)) begin
            n_bad++;
            $display("FAIL full_cycle p=%0d got=%b exp=%b", p, outs, exp_run(p));
         end
         n_cmp++;
         if ((clk1 & clk2) !== 1'b0) begin
            n_bad++;
            $display("FAIL no_overlap p=%0d clk1=%b clk2=%b", p, clk1, clk2);
         end
      end
   endtask

   task automatic test_din_enable();
      int          pts [13] = '{68, 87, 88, 118, 209, 237, 238, 277, 306, 339, 373, 374, 413};
      logic [12:0] exps     = 13'b1100_0011_1110_1;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         run_to(pts[i]);
         n_cmp++;
         if (ena !== exps[12 - i]) begin
            n_bad++;
            $display("FAIL din_enable p=%0d got=%b exp=%b", pts[i], ena, exps[12 - i]);
         end
      end
   endtask

   task automatic test_halt();
      do_reset();
      run_to(6 * 68 + 10);
      halt_req = 1'b1;
      run_to(542);
      n_cmp++;
      if (outs !== exp_run(542)) begin
         n_bad++;
         $display("FAIL pre_halt got=%b exp=%b", outs, exp_run(542));
      end
      run_to(543);
      n_cmp++;
      if (outs !== HALT_VEC) begin
         n_bad++;
         $display("FAIL halt_enter got=%b exp=%b", outs, HALT_VEC);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge sysclk);
         n_cmp++;
         if (outs !== HALT_VEC) begin
            n_bad++;
            $display("FAIL halt_hold cyc=%0d got=%b exp=%b", i, outs, HALT_VEC);
         end
      end
      halt_req = 1'b0;
      @(negedge sysclk);
      n_cmp++;
      if (outs !== RESUME_VEC) begin
         n_bad++;
         $display("FAIL halt_release got=%b exp=%b", outs, RESUME_VEC);
      end
      for (int p = 544; p < 544 + 150; p++) begin
         @(negedge sysclk);
         cur_p = p;
         n_cmp++;
         if (outs !== exp_run(p)) begin
            n_bad++;
            $display("FAIL halt_resume p=%0d got=%b exp=%b", p, outs, exp_run(p));
         end
      end
   endtask

   task automatic test_short_pulse();
      do_reset();
      for (int p = 0; p < 620; p++) begin
         @(negedge sysclk);
         cur_p = p;
         n_cmp++;
         if (outs !== exp_run(p)) begin
            n_bad++;
            $display("FAIL short_pulse p=%0d got=%b exp=%b", p, outs, exp_run(p));
         end
         // One-cycle pulses in A3 and one tick before the X3 sample point.
         halt_req = (p == 146) || (p == 541);
      end
      halt_req = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      run_to(4 * 68 + 39);
      poc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge sysclk);
         n_cmp++;
         if (outs !== 18'd0) begin
            n_bad++;
            $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, outs, 18'd0);
         end
      end
      poc = 1'b0;
      @(negedge sysclk);
      n_cmp++;
      if (outs !== 18'd0) begin
         n_bad++;
         $display("FAIL mid_release got=%b exp=%b", outs, 18'd0);
      end
      for (int p = 0; p < 80; p++) begin
         @(negedge sysclk);
         cur_p = p;
         n_cmp++;
         if (outs !== exp_run(p)) begin
            n_bad++;
            $display("FAIL mid_restart p=%0d got=%b exp=%b", p, outs, exp_run(p));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      poc = 1'b1;
      halt_req = 1'b0;
      test_reset();
      test_full_cycle();
      test_din_enable();
      test_halt();
      test_short_pulse();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Two-phase clock and subcycle timing generator for the i4004 core; it is the upstream stage of the scratchpad, ALU and instruction decode.
- Divides sysclk into 4004 subcycles. Each subcycle has one clk1 pulse then one clk2 pulse.
- Sequences the 8-subcycle instruction cycle A1 A2 A3 M1 M2 X1 X2 X3.
- Produces the registered phase strobes (a12…x32, m11, m21), SYNC, the derived din-latch enable, and a halt handshake for single-stepping.

Parameters:
- SUB_LEN, 68: sysclk cycles per subcycle (≈1.36 µs at 50 MHz). Must be greater than CLK2_START+CLK2_W.
- CLK1_START, 0: tick offset of clk1 rise within the subcycle.
- CLK1_W, 20: clk1 high width, in ticks.
- CLK2_START, 34: tick offset of clk2 rise. Must be at least CLK1_START+CLK1_W+1, so the clocks never overlap.
- CLK2_W, 20: clk2 high width, in ticks.

Ports:
- sysclk  in  1  50 MHz FPGA clock; the only clock.
- poc  in  1  Power-On Clear; synchronous, active-high reset.
- halt_req  in  1  Request to stop at the next instruction-cycle boundary.
- halt_ack  out  1  High while stopped.
- clk1  out  1  Phase-1 clock level.
- clk2  out  1  Phase-2 clock level.
- sync  out  1  SYNC; high for subcycle X3, clk1-aligned.
- a12, a22, a32, m12, m22, x12, x22, x32  out  1 each  Phase strobes, clk2-aligned.
- m11, m21  out  1 each  M1 and M2 strobes, clk1-aligned.
- m12_m22_clk1_m11_m12  out  1  Din-latch enable: m12 | m22 | (clk1 & ~(m11 | m12)).
- subcycle  out  3  Current subcycle index, 0 = A1 … 7 = X3.

Behaviour:
- Internal state:
  - tick counter t, range 0..SUB_LEN-1;
  - subcycle index s, range 0..7;
  - FSM with states RESET, RUN, HALT.
- Outputs: every output except m12_m22_clk1_m11_m12 is a register updated from the current (t, s). Outputs therefore lag the counter by exactly 1 sysclk. m12_m22_clk1_m11_m12 is combinational from the registered outputs.
- poc = 1:
  - forces RESET and sets t = 0, s = 0;
  - all outputs 0, including subcycle and halt_ack;
  - poc overrides halt_req and applies mid-subcycle with no completion of the current subcycle.
- RESET → RUN on the first edge with poc = 0.
- RUN, counter:
  - t increments each sysclk;
  - at t = SUB_LEN-1, t wraps to 0 and s increments, with 7 wrapping to 0.
- RUN, clocks:
  - clk1 is registered high iff CLK1_START ≤ t < CLK1_START+CLK1_W;
  - clk2 is registered high iff CLK2_START ≤ t < CLK2_START+CLK2_W.
- clk2-aligned strobes:
  - when t = CLK2_START, each xy2 is loaded with (s == its subcycle); a12 ↔ s = 0 … x32 ↔ s = 7;
  - each strobe is therefore high from clk2 of its subcycle to clk2 of the next subcycle;
  - exactly one strobe is high after the first clk2.
- clk1-aligned strobes: when t = CLK1_START:
  - m11 <= (s == 3);
  - m21 <= (s == 4);
  - sync <= (s == 7).
- subcycle output is registered from s.
- Halt handshake:
  - halt_req is sampled only at s = 7, t = SUB_LEN-1;
  - if sampled high, the FSM enters HALT instead of wrapping;
  - in HALT: t = 0, s = 0, clk1 = clk2 = 0, halt_ack = 1;
  - in HALT, x32 and sync hold their last values (1), all other strobes hold 0, and subcycle holds 7.
- HALT → RUN on the first edge with halt_req = 0:
  - halt_ack drops at that edge;
  - the next registered outputs reflect (t = 0, s = 0), i.e. the A1 clk1 rise.
- A halt_req pulse that is not high at the sample point is ignored.

Test Plan:
- Reset release: hold poc 5 cycles then drop → all outputs 0 during poc. After release, clk1 is high for 20 cycles starting 1 cycle after the release edge; clk2 rises 34 cycles after clk1 rises; a12 rises together with the first clk2.
- Full instruction cycle: run 8×68 cycles → strobes a12…x32 each high for 68 cycles, in order. m11 is high exactly across M1's clk1-to-clk1 window and sync across X3. clk1 and clk2 are never simultaneously high.
- Din-enable: during A2 the enable is high only while clk1 is high. During M1 it rises at the M1 clk2 (via m12) and stays high through the M2 clk1 pulse. During M2 clk2 it stays high via m22.
- Halt: assert halt_req during X2 and hold → at the end of X3, halt_ack = 1, clocks stay low for 100 cycles, and x32 = 1. Drop halt_req → on the next cycle halt_ack = 0, and clk1 rises on the following cycle with subcycle = 0.
- Short halt_req pulse: pulse halt_req for 1 cycle in A3 → no halt; cycle timing is unchanged.
- Mid-run reset: assert poc at t = 40 of M2 → all outputs 0 on the next cycle; the restart sequence is identical to the first scenario.
